// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding, default sample width and address helper
// for the clip record/playback datapath.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECORD = 2'b01,
        ST_PLAY   = 2'b10,
        ST_DRAIN  = 2'b11
    } state_t;

    localparam int SAMPLE_W_DEFAULT = 16;

    // Address is {clip, ptr}; the pointer never carries into the clip field.
    function automatic logic [31:0] compose_addr(input logic [31:0] clip, input logic [31:0] ptr,
                                                 input int ptr_w);
        return (clip << ptr_w) | ptr;
    endfunction

endpackage

// File: rtl/clip_len_table.sv
// clip_len_table: per-clip recorded length register file, one write port and
// two asynchronous read ports.
module clip_len_table #(
    parameter int NUM_CLIPS = 4,
    parameter int CLIP_W    = 2,
    parameter int LEN_W     = 11
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              we,
    input  logic [CLIP_W-1:0] waddr,
    input  logic [LEN_W-1:0]  wdata,
    input  logic [CLIP_W-1:0] raddr_a,
    input  logic [CLIP_W-1:0] raddr_b,
    output logic [LEN_W-1:0]  rdata_a,
    output logic [LEN_W-1:0]  rdata_b
);

    logic [LEN_W-1:0] len [NUM_CLIPS];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_CLIPS; i++) len[i] <= '0;
        end else if (we) begin
            len[waddr] <= wdata;
        end
    end

    assign rdata_a = len[raddr_a];
    assign rdata_b = len[raddr_b];

endmodule

// File: rtl/clip_sequencer.sv
// clip_sequencer: multi-clip record/playback controller driving a single-port
// sample RAM through a req/ack handshake, with loop, stop and overrun detection.
module clip_sequencer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter int NUM_CLIPS  = 4,
    parameter int CLIP_DEPTH = 1024,
    parameter int CLIP_W     = $clog2(NUM_CLIPS),
    parameter int PTR_W      = $clog2(CLIP_DEPTH)
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic                    play_i,
    input  logic                    record_i,
    input  logic                    stop_i,
    input  logic                    loop_i,
    input  logic [CLIP_W-1:0]       play_clip_i,
    input  logic [CLIP_W-1:0]       record_clip_i,
    input  logic                    sample_tick_i,
    input  logic [SAMPLE_W-1:0]     mic_sample_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [CLIP_W+PTR_W-1:0] mem_addr_o,
    output logic [SAMPLE_W-1:0]     mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [SAMPLE_W-1:0]     mem_rdata_i,
    output logic [SAMPLE_W-1:0]     spk_sample_o,
    output logic                    spk_valid_o,
    output logic [CLIP_W-1:0]       active_clip_o,
    output logic [1:0]              state_o,
    output logic                    overrun_o,
    output logic                    empty_err_o
);

    localparam int ADDR_W = CLIP_W + PTR_W;
    localparam int LEN_W  = PTR_W + 1;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CLIP_W-1:0]   clip_q, clip_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] wdata_q, wdata_d, spk_q, spk_d;
    logic                spk_valid_q, spk_valid_d, overrun_q, overrun_d, empty_q, empty_d;
    logic                len_we;
    logic [CLIP_W-1:0]   len_waddr;
    logic [LEN_W-1:0]    len_wdata, len_play, len_active, ptr_next;
    logic                ack, busy;

    clip_len_table #(.NUM_CLIPS(NUM_CLIPS), .CLIP_W(CLIP_W), .LEN_W(LEN_W)) u_len (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .we      (len_we),
        .waddr   (len_waddr),
        .wdata   (len_wdata),
        .raddr_a (play_clip_i),
        .raddr_b (clip_q),
        .rdata_a (len_play),
        .rdata_b (len_active)
    );

    assign ack      = req_q && mem_ack_i;
    assign busy     = state_q == ST_RECORD || state_q == ST_PLAY;
    assign ptr_next = LEN_W'(ptr_q) + LEN_W'(1);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            clip_q      <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            spk_q       <= '0;
            spk_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            clip_q      <= clip_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            spk_q       <= spk_d;
            spk_valid_q <= spk_valid_d;
            overrun_q   <= overrun_d;
            empty_q     <= empty_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clip_d      = clip_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        spk_d       = spk_q;
        spk_valid_d = 1'b0;
        overrun_d   = overrun_q;
        empty_d     = 1'b0;
        len_we      = 1'b0;
        len_waddr   = clip_q;
        len_wdata   = ptr_next;
        // A completing access always lands its side effect, whatever the state does next.
        if (ack) begin
            req_d = 1'b0;
            if (we_q) len_we = 1'b1;
            else begin
                spk_d       = mem_rdata_i;
                spk_valid_d = 1'b1;
            end
        end
        if (state_q == ST_IDLE) begin
            if (record_i) begin
                state_d   = ST_RECORD;
                ptr_d     = '0;
                clip_d    = record_clip_i;
                len_we    = 1'b1;
                len_waddr = record_clip_i;
                len_wdata = '0;
            end else if (play_i) begin
                if (len_play != '0) begin
                    state_d = ST_PLAY;
                    ptr_d   = '0;
                    clip_d  = play_clip_i;
                end else empty_d = 1'b1;
            end
        end else if (busy) begin
            if (sample_tick_i && req_q) overrun_d = 1'b1;
            else if (sample_tick_i && !stop_i) begin
                req_d  = 1'b1;
                we_d   = state_q == ST_RECORD;
                addr_d = ADDR_W'(compose_addr(32'(clip_q), 32'(ptr_q), PTR_W));
                if (state_q == ST_RECORD) wdata_d = mic_sample_i;
            end
            if (ack) begin
                ptr_d = ptr_q + PTR_W'(1);
                if (state_q == ST_RECORD && ptr_next[PTR_W]) state_d = ST_IDLE;
                if (state_q == ST_PLAY && ptr_next == len_active) begin
                    ptr_d   = loop_i ? '0 : ptr_d;
                    state_d = loop_i ? ST_PLAY : ST_IDLE;
                end
            end
            if (stop_i) state_d = (req_q && !mem_ack_i) ? ST_DRAIN : ST_IDLE;
        end else if (ack) state_d = ST_IDLE;
    end

    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign spk_sample_o  = spk_q;
    assign spk_valid_o   = spk_valid_q;
    assign active_clip_o = clip_q;
    assign state_o       = state_q;
    assign overrun_o     = overrun_q;
    assign empty_err_o   = empty_q;

endmodule

// File: doc/clip_sequencer.md
Name: clip_sequencer

Overview:
- Multi-clip record/playback controller for the audio recorder datapath.
- Sits between the PDM decimator (mic samples in), the PWM speaker driver (samples out) and a single-port sample RAM.
- Generalises the two-clip play/record control to NUM_CLIPS clips of CLIP_DEPTH samples each.
- Adds per-clip length tracking, loop mode, stop command, and a req/ack memory handshake with overrun detection.

Parameters:
SAMPLE_W, 16, audio sample width in bits
NUM_CLIPS, 4, number of clips; power of two, >= 2
CLIP_DEPTH, 1024, samples per clip; power of two
CLIP_W, $clog2(NUM_CLIPS), clip select width (derived)
PTR_W, $clog2(CLIP_DEPTH), in-clip pointer width (derived)

Ports:
clock_i  in  1  system clock, 100 MHz
reset_ni  in  1  reset, asynchronous, active-low
play_i  in  1  single-cycle play command pulse
record_i  in  1  single-cycle record command pulse
stop_i  in  1  single-cycle stop command pulse
loop_i  in  1  level; 1 = playback wraps to sample 0 at end of clip
play_clip_i  in  CLIP_W  clip index used by play_i
record_clip_i  in  CLIP_W  clip index used by record_i
sample_tick_i  in  1  one-cycle strobe at the audio sample rate
mic_sample_i  in  SAMPLE_W  current microphone sample, valid on sample_tick_i
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  CLIP_W+PTR_W  address = {clip, ptr}
mem_wdata_o  out  SAMPLE_W  write data
mem_ack_i  in  1  one-cycle acknowledge; read data valid in the same cycle
mem_rdata_i  in  SAMPLE_W  read data
spk_sample_o  out  SAMPLE_W  playback sample, held between updates
spk_valid_o  out  1  one-cycle pulse when spk_sample_o updates
active_clip_o  out  CLIP_W  clip currently recorded/played (for seven-segment display)
state_o  out  2  00 IDLE, 01 RECORD, 10 PLAY, 11 DRAIN
overrun_o  out  1  sticky; a tick arrived while a request was still pending
empty_err_o  out  1  one-cycle pulse when play is requested on a zero-length clip

Behaviour:
- Reset values: every output is 0; all clip lengths are 0; the pointer is 0. Reset mid-operation aborts any pending request immediately, with no ack wait.
- IDLE:
  - record_i -> RECORD: ptr=0; active_clip latched from record_clip_i; that clip's length cleared to 0.
  - play_i with len[play_clip_i] != 0 -> PLAY: ptr=0; active_clip latched from play_clip_i.
  - play_i with len == 0 -> stay in IDLE and pulse empty_err_o.
  - record_i and play_i in the same cycle: record wins.
- Commands received outside IDLE: play_i and record_i are ignored. stop_i -> DRAIN if mem_req_o is high, otherwise -> IDLE.
- RECORD:
  - On sample_tick_i with no pending request: assert mem_req_o, mem_we_o=1, addr={active_clip, ptr}, wdata=mic_sample_i (captured and held).
  - On mem_ack_i: ptr+1 and len[active_clip]=ptr+1.
  - When the write at ptr=CLIP_DEPTH-1 is acked: len=CLIP_DEPTH, then -> IDLE (auto stop). No wrap.
- PLAY:
  - On sample_tick_i with no pending request: read at {active_clip, ptr}.
  - On mem_ack_i: spk_sample_o=mem_rdata_i, pulse spk_valid_o, ptr+1.
  - If ptr+1 == len: loop_i=1 sets ptr=0; otherwise -> IDLE.
  - loop_i is sampled at each end-of-clip; it is not latched at start.
- DRAIN: wait for mem_ack_i, complete the pending access's side effects (length update or speaker update), then -> IDLE.
- Overrun: sample_tick_i while mem_req_o=1 in RECORD/PLAY drops that tick and sets overrun_o. It stays set until reset.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and stable while a request is pending. Latency from tick to mem_req_o is 1 cycle.
- A tick and an ack in the same cycle: the ack completes, and the tick counts as an overrun (request was still pending that cycle).
- Lengths are stored as PTR_W+1 bits, so CLIP_DEPTH is representable. Address arithmetic is unsigned with no carry into the clip field.

Decomposition:
- Package audio_pkg:
  - state enum (IDLE, RECORD, PLAY, DRAIN) with 2-bit encoding
  - default SAMPLE_W
  - address-compose helper function
- Sub-module clip_len_table: NUM_CLIPS x (PTR_W+1) register file with one write port and two read ports (play select, active clip). Asynchronous active-low clear.
- The FSM and memory handshake stay in clip_sequencer.

Test Plan (NUM_CLIPS=4, CLIP_DEPTH=8, memory model acks 2 cycles after req):
- Reset with reset_ni low mid-RECORD -> all outputs 0 and state_o=00 asynchronously; a subsequent play of clip 0 pulses empty_err_o.
- Record clip 2 with mic samples 0x0011..0x0088 on 8 ticks -> 8 writes to addr 16..23, auto-return to IDLE, len[2]=8.
- Record clip 1 for 3 ticks then stop_i issued while a request is pending -> DRAIN until ack, len[1]=3. Play clip 1 with loop_i=0 -> 3 spk_valid_o pulses, then IDLE.
- Play clip 2 with loop_i=1 for 10 ticks -> spk sequence 0x11..0x88, 0x11, 0x22. Drop loop_i -> stops after the next 0x88.
- Assert play_i and record_i together in IDLE -> RECORD entered, no read issued.
- Slow memory (ack after 12 cycles) with back-to-back ticks every 10 cycles -> overrun_o set and ticks dropped; addresses stay contiguous.
